// File: rtl/timer_pkg.sv
// Shared constants for the timer compare array: status bit layout and default sizing.
package timer_pkg;

    localparam int unsigned ST_OVF        = 0;
    localparam int unsigned ST_UDF        = 1;
    localparam int unsigned ST_MATCH_BASE = 2;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NCH   = 4;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_cmp_chan.sv
// One compare channel: writable compare register, registered match pulse, sticky status bit.
module timer_cmp_chan
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SELW  = 2,
    parameter int unsigned IDX   = 0
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             q,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] last_cnt,
    input  logic             cmp_we,
    input  logic [SELW-1:0]  cmp_sel,
    input  logic [WIDTH-1:0] cmp_wdata,
    input  logic             clr,
    output logic             match_trig,
    output logic             stat
);

    logic [WIDTH-1:0] cmp_val;
    logic             hit;
    logic             we_hit;

    // Compare against the register's current value so a same-edge write is not seen yet.
    assign hit    = q && (cnt == cmp_val) && (cnt != last_cnt);
    assign we_hit = cmp_we && (cmp_sel == SELW'(IDX));

    always_ff @(posedge pclk) begin
        if (preset) begin
            cmp_val    <= '1;
            match_trig <= 1'b0;
            stat       <= 1'b0;
        end else begin
            if (we_hit)
                cmp_val <= cmp_wdata;
            match_trig <= hit;
            stat       <= hit | (stat & ~clr);
        end
    end

endmodule

// File: rtl/timer_cmp_array.sv
// Timer compare array: wrap detection, NCH compare channels, sticky status and interrupt.
// Define TMR_CMP_IRQ_MASK_EN to gate the interrupt with irq_mask; otherwise any status bit raises irq.
module timer_cmp_array
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [WIDTH-1:0]            cnt,
    input  logic [WIDTH-1:0]            last_cnt,
    input  logic                        en,
    input  logic                        load,
    input  logic                        updown,
    input  logic                        cmp_we,
    input  logic [sel_width(NCH)-1:0]   cmp_sel,
    input  logic [WIDTH-1:0]            cmp_wdata,
    input  logic [NCH+1:0]              stat_clr,
    input  logic [NCH+1:0]              irq_mask,
    output logic                        ovf_trig,
    output logic                        udf_trig,
    output logic [NCH-1:0]              match_trig,
    output logic [NCH+1:0]              status,
    output logic                        irq
);

    localparam int unsigned SELW = sel_width(NCH);

    logic           q;
    logic           ovf_hit;
    logic           udf_hit;
    logic           st_ovf;
    logic           st_udf;
    logic [NCH-1:0] st_match;

    assign q       = en & ~load;
    assign ovf_hit = q & ~updown & (last_cnt == '1) & (cnt == '0);
    assign udf_hit = q &  updown & (last_cnt == '0) & (cnt == '1);

    always_ff @(posedge pclk) begin
        if (preset) begin
            ovf_trig <= 1'b0;
            udf_trig <= 1'b0;
            st_ovf   <= 1'b0;
            st_udf   <= 1'b0;
        end else begin
            ovf_trig <= ovf_hit;
            udf_trig <= udf_hit;
            st_ovf   <= ovf_hit | (st_ovf & ~stat_clr[ST_OVF]);
            st_udf   <= udf_hit | (st_udf & ~stat_clr[ST_UDF]);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        timer_cmp_chan #(
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .IDX   (i)
        ) u_chan (
            .pclk       (pclk),
            .preset     (preset),
            .q          (q),
            .cnt        (cnt),
            .last_cnt   (last_cnt),
            .cmp_we     (cmp_we),
            .cmp_sel    (cmp_sel),
            .cmp_wdata  (cmp_wdata),
            .clr        (stat_clr[ST_MATCH_BASE+i]),
            .match_trig (match_trig[i]),
            .stat       (st_match[i])
        );
    end

    assign status = {st_match, st_udf, st_ovf};

`ifdef TMR_CMP_IRQ_MASK_EN
    assign irq = |(status & irq_mask);
`else
    logic unused_irq_mask;
    assign unused_irq_mask = ^irq_mask;
    assign irq = |status;
`endif

endmodule

// File: tb/tb_timer_cmp_array.sv
// Directed-vector bench for timer_cmp_array with a queue-based scoreboard.
module tb_timer_cmp_array;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [31:0] cnt = '0;
    logic [31:0] last_cnt = '0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        updown = 1'b0;
    logic        cmp_we = 1'b0;
    logic [1:0]  cmp_sel = '0;
    logic [31:0] cmp_wdata = '0;
    logic [5:0]  stat_clr = '0;
    logic [5:0]  irq_mask = '1;
    logic        ovf_trig;
    logic        udf_trig;
    logic [3:0]  match_trig;
    logic [5:0]  status;
    logic        irq;

    timer_cmp_array #(.WIDTH(32), .NCH(4)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cnt        (cnt),
        .last_cnt   (last_cnt),
        .en         (en),
        .load       (load),
        .updown     (updown),
        .cmp_we     (cmp_we),
        .cmp_sel    (cmp_sel),
        .cmp_wdata  (cmp_wdata),
        .stat_clr   (stat_clr),
        .irq_mask   (irq_mask),
        .ovf_trig   (ovf_trig),
        .udf_trig   (udf_trig),
        .match_trig (match_trig),
        .status     (status),
        .irq        (irq)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        rst, en, load, ud;
        logic [31:0] cnt, last;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] wd;
        logic [5:0]  clr;
        logic        ovf, udf;
        logic [3:0]  m;
        logic [5:0]  st;
        logic        irq;
    } vec_t;

    typedef struct {
        int          id;
        logic        ovf, udf;
        logic [3:0]  m;
        logic [5:0]  st;
        logic        irq;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t e;
    int   applied = 0;
    int   miscompares = 0;

    task automatic add(input logic rst, input logic en_i, input logic ld, input logic ud,
                       input logic [31:0] last, input logic [31:0] c,
                       input logic we, input logic [1:0] sel, input logic [31:0] wd,
                       input logic [5:0] clr,
                       input logic ovf, input logic udf, input logic [3:0] m,
                       input logic [5:0] st, input logic ir);
        vec_t v;
        v.rst = rst; v.en = en_i; v.load = ld; v.ud = ud; v.last = last; v.cnt = c;
        v.we = we; v.sel = sel; v.wd = wd; v.clr = clr;
        v.ovf = ovf; v.udf = udf; v.m = m; v.st = st; v.irq = ir;
        vecs.push_back(v);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set; check it against the queue head.
    always @(posedge pclk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            applied++;
            if (ovf_trig !== e.ovf || udf_trig !== e.udf || match_trig !== e.m ||
                status !== e.st || irq !== e.irq) begin
                miscompares++;
                $display("FAIL vec%0d: got ovf=%b udf=%b match=%b status=%b irq=%b, want ovf=%b udf=%b match=%b status=%b irq=%b",
                         e.id, ovf_trig, udf_trig, match_trig, status, irq,
                         e.ovf, e.udf, e.m, e.st, e.irq);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    initial begin
        //   rst en ld ud last        cnt         we sel wdata       clr        ovf udf match    status     irq
        add(1, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 0 reset
        add(1, 1, 0, 0, ONES,       32'h0,      1, 2, 32'h5,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 1 wrap+write under reset
        add(0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 2 idle
        add(0, 1, 0, 0, 32'h1F,     32'h20,     1, 0, 32'h20,  6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 3 write ch0 same edge
        add(0, 1, 0, 0, 32'h20,     32'h21,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 4
        add(0, 1, 0, 0, 32'h1F,     32'h20,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0001, 6'b000100, 1); // 5 ch0 match
        add(0, 1, 0, 0, 32'h4,      32'h5,      0, 0, 32'h0,   6'b000100, 0, 0, 4'b0000, 6'b000000, 0); // 6 clear; ch2 still all-ones
        add(0, 0, 0, 0, 32'h0,      32'h0,      1, 1, 32'h30,  6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 7 ch1=30
        add(0, 0, 0, 0, 32'h0,      32'h0,      1, 2, 32'h10,  6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 8 ch2=10
        add(0, 0, 0, 0, 32'h0,      32'h0,      1, 3, 32'h40,  6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 9 ch3=40
        add(0, 1, 0, 0, ONES,       32'h0,      0, 0, 32'h0,   6'b000000, 1, 0, 4'b0000, 6'b000001, 1); // 10 overflow
        add(0, 1, 0, 0, 32'h0,      32'h1,      0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000001, 1); // 11 sticky
        add(0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b000001, 0, 0, 4'b0000, 6'b000000, 0); // 12 clear ovf
        add(0, 1, 1, 1, 32'h0,      ONES,       0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 13 underflow with load
        add(0, 1, 0, 1, 32'h0,      ONES,       0, 0, 32'h0,   6'b000000, 0, 1, 4'b0000, 6'b000010, 1); // 14 underflow
        add(0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b000010, 0, 0, 4'b0000, 6'b000000, 0); // 15 clear udf
        add(0, 1, 0, 0, 32'h0F,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0100, 6'b010000, 1); // 16 ch2 match
        add(0, 1, 0, 0, 32'h10,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b010000, 1); // 17 stalled
        add(0, 1, 0, 0, 32'h10,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b010000, 1); // 18 stalled
        add(0, 1, 0, 0, 32'h10,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b010000, 1); // 19 stalled
        add(0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b010000, 0, 0, 4'b0000, 6'b000000, 0); // 20 clear ch2
        add(0, 1, 0, 0, 32'h2F,     32'h30,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0010, 6'b001000, 1); // 21 ch1 match
        add(0, 1, 0, 1, 32'h31,     32'h30,     0, 0, 32'h0,   6'b001000, 0, 0, 4'b0010, 6'b001000, 1); // 22 set beats clear, down
        add(0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 32'h0,   6'b001000, 0, 0, 4'b0000, 6'b000000, 0); // 23 clear ch1
        add(0, 0, 0, 0, 32'h0,      32'h0,      1, 3, 32'h10,  6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 24 ch3=10
        add(0, 1, 0, 0, 32'h0F,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b1100, 6'b110000, 1); // 25 ch2+ch3 together
        add(0, 1, 0, 0, ONES,       32'h0,      0, 0, 32'h0,   6'b110000, 1, 0, 4'b0000, 6'b000001, 1); // 26 ovf while clearing
        add(1, 1, 0, 1, 32'h0,      ONES,       0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 27 reset during wrap
        add(0, 1, 0, 0, 32'h0F,     32'h10,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b0000, 6'b000000, 0); // 28 ch2 back to all-ones
        add(0, 1, 0, 0, 32'hFFFFFFFE, ONES,     0, 0, 32'h0,   6'b000000, 0, 0, 4'b1111, 6'b111100, 1); // 29 all channels all-ones
        add(0, 0, 0, 0, ONES,       32'h0,      0, 0, 32'h0,   6'b111100, 0, 0, 4'b0000, 6'b000000, 0); // 30 en=0 wrap ignored

        foreach (vecs[k]) begin
            exp_t x;
            @(negedge pclk);
            preset    = vecs[k].rst;
            en        = vecs[k].en;
            load      = vecs[k].load;
            updown    = vecs[k].ud;
            last_cnt  = vecs[k].last;
            cnt       = vecs[k].cnt;
            cmp_we    = vecs[k].we;
            cmp_sel   = vecs[k].sel;
            cmp_wdata = vecs[k].wd;
            stat_clr  = vecs[k].clr;
            x.id  = k;
            x.ovf = vecs[k].ovf;
            x.udf = vecs[k].udf;
            x.m   = vecs[k].m;
            x.st  = vecs[k].st;
            x.irq = vecs[k].irq;
            exp_q.push_back(x);
        end
        @(negedge pclk);
        @(negedge pclk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_cmp_array.md
TIMER_CMP_ARRAY -- requirements
Module: timer_cmp_array

Interface
REQ-001 WIDTH, 32, counter and compare-value width in bits (>=2).
REQ-002 NCH, 4, number of compare channels (1..16).
REQ-003 pclk  input  1  sole clock; all state updates on rising edge.
REQ-004 preset  input  1  reset; synchronous, active-high.
REQ-005 cnt  input  WIDTH  current counter value.
REQ-006 last_cnt  input  WIDTH  counter value of the previous cycle.
REQ-007 en  input  1  counter enabled.
REQ-008 load  input  1  counter loaded this cycle; suppresses all events.
REQ-009 updown  input  1  0 = count up, 1 = count down.
REQ-010 cmp_we  input  1  compare-value write strobe.
REQ-011 cmp_sel  input  max(1,$clog2(NCH))  channel addressed by the write.
REQ-012 cmp_wdata  input  WIDTH  compare value to write.
REQ-013 stat_clr  input  NCH+2  write-1-to-clear mask for status.
REQ-014 irq_mask  input  NCH+2  per-event interrupt enable.
REQ-015 ovf_trig  output  1  one-cycle overflow pulse.
REQ-016 udf_trig  output  1  one-cycle underflow pulse.
REQ-017 match_trig  output  NCH  per-channel one-cycle match pulse.
REQ-018 status  output  NCH+2  sticky flags: bit0 ovf, bit1 udf, bit 2+i channel i.
REQ-019 irq  output  1  level interrupt.

Function
REQ-020 Qualifier q = en & !load; with q=0 no trigger or status bit shall be set.
REQ-021 ovf_trig shall be 1 for exactly the cycle after an edge sampling q & !updown & last_cnt==all-ones & cnt==0, else 0 (registered, latency 1).
REQ-022 udf_trig shall follow the same rule with q & updown & last_cnt==0 & cnt==all-ones.
REQ-023 match_trig[i] shall pulse one cycle after an edge sampling q & cnt==cmp_val[i] & cnt!=last_cnt; a stalled counter holding the value yields a single pulse.
REQ-024 Match is direction-independent; channels with equal values pulse together; match and ovf/udf may pulse in the same cycle.
REQ-025 cmp_val[cmp_sel] shall update on an edge with cmp_we; a comparison on that same edge uses the old value; writes with cmp_sel>=NCH are ignored.
REQ-026 Each status bit shall set on the edge its trigger registers and hold until its stat_clr bit is 1 on an edge; set and clear on the same edge -> set wins.
REQ-027 irq shall be combinational from status (and mask), with no added latency.
REQ-028 All comparisons are unsigned WIDTH-bit equality; no carry or sign.

Reset
REQ-029 With preset=1 at an edge: all triggers and status 0, every cmp_val all-ones, irq 0; preset overrides every input including cmp_we.
REQ-030 An event qualifying on a reset edge shall be discarded; the first possible pulse follows the first edge with preset=0.

Configuration
REQ-031 TMR_CMP_IRQ_MASK_EN defined: irq = |(status & irq_mask); undefined: irq_mask port kept but ignored, irq = |status.

Structure
REQ-032 Package timer_pkg holds status index constants (ST_OVF=0, ST_UDF=1, ST_MATCH_BASE=2) and default WIDTH/NCH localparams.
REQ-033 Sub-module timer_cmp_chan (cmp_val register, match pulse, sticky bit) shall be generated NCH times; wrap detection stays in the top level.

Verification
REQ-034 Up, last_cnt=FFFFFFFF, cnt=0, en=1, load=0, mask=all-ones -> ovf_trig=1 one cycle later for one cycle, status[0]=1, irq=1.
REQ-035 Down 0->FFFFFFFF with load=1 -> no udf_trig; repeat with load=0 -> udf_trig pulse, status[1]=1.
REQ-036 cmp_val[2]=0x10, count 0x0F->0x10 -> match_trig=4'b0100 one cycle; hold cnt=0x10 three cycles -> no further pulse.
REQ-037 stat_clr[3]=1 on the same edge as a new channel-1 match -> status[3] stays 1; clear again with no event -> 0, irq falls same cycle.
REQ-038 cmp_we ch0=0x20 on the edge where cnt goes 0x1F->0x20 -> no match (old value all-ones); next pass through 0x20 -> match_trig[0] pulse.
REQ-039 preset=1 during a wrap event -> no pulse, status 0, cmp_val all-ones, irq 0.
